// File: rtl/seq_match_scheduler.sv
// Round-robin front end that feeds words from two requesters MSB-first through
// a bit-serial overlapping pattern detector and reports the match count per word.
module seq_match_scheduler #(
  parameter int                 WIDTH   = 8,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             grant0,
  output logic             grant1,
  output logic             busy,
  output logic             bit_out,
  output logic             match,
  output logic [3:0]       count,
  output logic             owner,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);
  localparam logic [3:0] MIN_IDX  = 4'(PAT_LEN - 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [PAT_LEN-2:0] hist_reg, hist_next;
  logic [3:0]         idx_reg, idx_next;
  logic [3:0]         count_reg, count_next;
  logic               owner_reg, owner_next;
  logic               last_reg, last_next;
  logic               grant0_reg, grant0_next;
  logic               grant1_reg, grant1_next;
  logic               match_reg, match_next;

  logic               winner;
  logic [PAT_LEN-1:0] window;
  logic               hit;

  assign bit_out = (state_reg == SHIFT) && shift_reg[WIDTH-1];
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign grant0  = grant0_reg;
  assign grant1  = grant1_reg;
  assign match   = match_reg;
  assign count   = count_reg;
  assign owner   = owner_reg;

  // Detector window: previous PAT_LEN-1 bits of this word plus the bit now on bit_out.
  assign window = {hist_reg, bit_out};
  assign hit    = (state_reg == SHIFT) && (window == PATTERN) && (idx_reg >= MIN_IDX);
  assign winner = (req0 && req1) ? ~last_reg : req1;

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    hist_next   = hist_reg;
    idx_next    = idx_reg;
    count_next  = count_reg;
    owner_next  = owner_reg;
    last_next   = last_reg;
    grant0_next = 1'b0;
    grant1_next = 1'b0;
    match_next  = 1'b0;
    case (state_reg)
      // The DONE edge also accepts a pending request, so back-to-back words
      // keep a spacing of WIDTH+1 cycles.
      IDLE, DONE: begin
        if (state_reg == DONE) state_next = IDLE;
        if (req0 || req1) begin
          state_next  = SHIFT;
          shift_next  = winner ? data1 : data0;
          hist_next   = '0;
          idx_next    = '0;
          count_next  = '0;
          owner_next  = winner;
          last_next   = winner;
          grant0_next = ~winner;
          grant1_next = winner;
        end
      end
      SHIFT: begin
        shift_next = {shift_reg[WIDTH-2:0], 1'b0};
        hist_next  = window[PAT_LEN-2:0];
        idx_next   = idx_reg + 4'd1;
        match_next = hit;
        if (hit) count_next = count_reg + 4'd1;
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      hist_reg   <= '0;
      idx_reg    <= '0;
      count_reg  <= '0;
      owner_reg  <= 1'b0;
      last_reg   <= 1'b1;
      grant0_reg <= 1'b0;
      grant1_reg <= 1'b0;
      match_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      hist_reg   <= hist_next;
      idx_reg    <= idx_next;
      count_reg  <= count_next;
      owner_reg  <= owner_next;
      last_reg   <= last_next;
      grant0_reg <= grant0_next;
      grant1_reg <= grant1_next;
      match_reg  <= match_next;
    end
  end

endmodule

// File: tb/tb_seq_match_scheduler.sv
// Scoreboard bench for seq_match_scheduler: stimulus predicts each accepted word,
// a negedge monitor pops predictions and compares grants, pulses, bits and totals.
module tb_seq_match_scheduler;

  localparam int           W   = 8;
  localparam int           P   = 4;
  localparam logic [P-1:0] PAT = 4'b1011;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         grant0, grant1, busy, bit_out, match, owner, done;
  logic [3:0]   count;

  seq_match_scheduler #(.WIDTH(W), .PAT_LEN(P), .PATTERN(PAT)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .grant0(grant0), .grant1(grant1), .busy(busy), .bit_out(bit_out), .match(match),
    .count(count), .owner(owner), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [3:0]  count;
    logic [15:0] mask;   // expected match pulse per cycle offset after the grant edge
    logic [15:0] bits;   // expected bit_out per cycle offset
    int          gap;    // expected cycles since previous grant, or -1
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   errors = 0;
  logic model_last = 1'b1;
  bit   mon_active = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: slide a PAT-wide window over the word, MSB first, counting overlaps.
  function automatic exp_t model(logic own, logic [W-1:0] d, int gap);
    exp_t e;
    logic [P-1:0] win;
    e.owner = own; e.count = '0; e.mask = '0; e.bits = '0; e.gap = gap;
    for (int k = 0; k < W; k++) e.bits[k] = d[W-1-k];
    for (int i = 0; i <= W - P; i++) begin
      win = d[W-1-i -: P];
      if (win == PAT) begin
        e.count = e.count + 4'd1;
        e.mask[i+P] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic predict(logic r0, logic r1);
    logic w;
    w = (r0 && r1) ? ~model_last : r1;
    model_last = w;
    return w;
  endfunction

  task automatic wait_grant();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(grant0 || grant1) && n < 40);
    chk("grant_seen", grant0 || grant1, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  // One request cycle: single requester, or both (winner drops first).
  task automatic transact(logic r0, logic r1, logic [W-1:0] d0, logic [W-1:0] d1);
    logic w;
    data0 = d0; data1 = d1;
    req0 = r0; req1 = r1;
    w = predict(r0, r1);
    expq.push_back(model(w, w ? d1 : d0, -1));
    if (r0 && r1) begin
      w = predict(~w, w);
      expq.push_back(model(w, w ? d1 : d0, W + 1));
    end
    wait_grant();
    if (r0 && r1) begin
      if (w) req0 = 1'b0; else req1 = 1'b0;
      wait_grant();
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // Requests held high across n consecutive grants.
  task automatic hold_run(logic r0, logic r1, int n);
    logic w;
    data0 = W'($urandom); data1 = W'($urandom);
    req0 = r0; req1 = r1;
    for (int i = 0; i < n; i++) begin
      w = predict(r0, r1);
      expq.push_back(model(w, w ? data1 : data0, (i == 0) ? -1 : W + 1));
    end
    for (int i = 0; i < n; i++) wait_grant();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t        cur;
    int          cyc = 0, last_grant_cyc = 0, off = 0, words = 0;
    logic [15:0] mask_seen = '0, bits_seen = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("reset_quiet", {done, match}, 0);
        expq.delete();
        mon_active = 1'b0;
      end else begin
        if (grant0 || grant1) begin
          if (expq.size() == 0) begin
            chk("unexpected_grant", {grant1, grant0}, 0);
          end else begin
            cur = expq.pop_front();
            chk("grant_owner", {grant1, grant0}, cur.owner ? 2 : 1);
            if (cur.gap > 0) chk("grant_gap", cyc - last_grant_cyc, cur.gap);
            mon_active = 1'b1; off = 0; mask_seen = '0; bits_seen = '0;
          end
          last_grant_cyc = cyc;
        end
        if (mon_active) begin
          chk("busy", busy, 1);
          mask_seen[off] = match;
          bits_seen[off] = bit_out;
          if (done) begin
            chk("done_offset", off, W);
            chk("owner", owner, cur.owner);
            chk("count", count, cur.count);
            chk("match_pulses", mask_seen, cur.mask);
            chk("bit_out", bits_seen, cur.bits);
            words++;
            $display("word %0d: owner=%0d count=%0d matches=%b", words, owner, count, mask_seen[W:0]);
            mon_active = 1'b0;
          end else if (off >= W) begin
            chk("done_timeout", done, 1);
            mon_active = 1'b0;
          end
          off++;
        end else if (match || done) begin
          chk("spurious_pulse", {match, done}, 0);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    #12;
    chk("rst_outputs", {grant0, grant1, busy, bit_out, match, done, owner}, 0);
    chk("rst_count", count, 0);
    #10 reset = 1'b0;
    @(negedge clk);

    transact(1, 0, 8'b10110110, 8'h00);
    transact(1, 0, 8'b11111111, 8'h00);
    transact(1, 0, 8'b10111011, 8'h00);

    do_reset();
    transact(1, 1, 8'b10110110, 8'b00001011);
    hold_run(1, 1, 4);
    hold_run(1, 0, 3);

    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 2);
      transact(n != 1, n != 0, W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    // Abandon a word mid-flight, four cycles after its grant.
    transact(1, 0, 8'b10110110, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_outputs", {grant0, grant1, busy, bit_out, match, done, owner}, 0);
    chk("midrst_count", count, 0);
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    transact(1, 1, 8'b00101100, 8'b01011011);

    n = 0;
    while ((expq.size() != 0 || mon_active) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", expq.size() + int'(mon_active), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_match_scheduler.md
# seq_match_scheduler

- Shares one serial pattern-match datapath between two requesters, scheduled round-robin.
- A granted requester hands over a WIDTH-bit word. The block serializes the word MSB-first through a bit-serial sequence detector, then reports the number of overlapping PATTERN matches.
- It is the sequencing layer for the team's single-bit-input, single-bit-output detector FSM, which it contains. Callers never drive the detector directly.

## Interface
- WIDTH, default 8: bits per word; legal range 4..15.
- PAT_LEN, default 4: pattern length; legal range 2..WIDTH.
- PATTERN, default 4'b1011: pattern to detect, PAT_LEN bits wide; its MSB is the first bit in time.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0, req1  input  1  service request from requester 0 / 1.
- data0, data1  input  WIDTH  word from requester 0 / 1; must be stable while the matching req is high.
- grant0, grant1  output  1  one-cycle pulse: word accepted from requester 0 / 1.
- busy  output  1  high while a word is being processed (state != IDLE).
- bit_out  output  1  serial bit currently presented to the detector.
- match  output  1  one-cycle pulse per detected pattern occurrence.
- count  output  4  number of matches in the current or last word.
- owner  output  1  requester that owns the current or last word.
- done  output  1  one-cycle pulse: count and owner are final.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Any req high at an edge:
    - Arbitrate and latch the winner's data into the shift register.
    - owner <= winner.
    - Pulse the winner's grant in the next cycle.
    - Clear count, the bit index and the detector history.
    - Go to SHIFT.
- Arbitration:
  - Pointer last reset value is 1, so req0 wins first after reset.
  - Only one req high: grant that requester.
  - Both high: grant the requester != last.
  - last <= owner at each grant.
- SHIFT:
  - bit_out = shift register MSB.
  - Each edge: shift left, append bit_out to the detector history, increment the bit index.
  - After the edge consuming bit WIDTH-1: go to DONE.
- Detector, evaluated at each SHIFT edge:
  - Match when {last PAT_LEN-1 history bits, bit_out} == PATTERN and at least PAT_LEN bits of this word have been consumed.
  - Overlapping matches count.
  - History is cleared per word, so matches never span two words.
  - Each match registers match=1 for the following cycle and increments count.
  - count cannot overflow: maximum is WIDTH-PAT_LEN+1 <= 14.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: IDLE.
  - count and owner hold until the next grant edge.
- Requester protocol:
  - Hold req and data until grant is seen; drop req in the grant cycle.
  - A req still high at the next IDLE edge is a new request.
- bit_out is 0 outside SHIFT.
- Reset, asynchronous at any time including mid-word:
  - grant0, grant1, busy, bit_out, match, done = 0.
  - count = 0, owner = 0, last = 1, state IDLE.
  - The in-flight word is abandoned, with no done and no match.

## Timing
- Edge E0: accepting edge in IDLE.
- Cycle after E0: grant pulse, busy=1, bit_out = data bit WIDTH-1 (MSB).
- Bit k (k=0 is the MSB) is consumed at edge E0+k+1.
- A match on bit k pulses match during the cycle after edge E0+k+1.
- done is high during the cycle after edge E0+WIDTH; busy is still 1 in that cycle.
- Earliest next accepting edge is E0+WIDTH+1, giving a throughput of one word per WIDTH+1 cycles.
- The match pulse for the final bit coincides with done.

## Test plan
All scenarios use defaults (WIDTH=8, PATTERN=1011, PAT_LEN=4).

- **Basic match:** after reset, req0=1 with data0=8'b10110110.
  - grant0 pulses after E0.
  - match pulses after edges E0+4 and E0+7.
  - done after E0+8 with count=2, owner=0.
- **No / end-of-word match:**
  - data0=8'b11111111 -> count=0, no match pulse, done still asserted.
  - data0=8'b10111011 -> count=2, with the second match pulse coincident with done.
- **Simultaneous requests:** req0 and req1 both high after reset, data1=8'b00001011.
  - Requester 0 is served first.
  - grant1 at edge E0+9.
  - Second done: count=1, owner=1.
- **Round-robin fairness:** req0 and req1 held high continuously -> grants alternate 0,1,0,1 at 9-cycle spacing.
- **Single holder:** req0 held high, req1 low -> req0 re-granted at edges E0, E0+9, E0+18.
- **Reset mid-word:** assert reset 4 cycles after grant0.
  - All outputs 0 immediately; no done.
  - After release, req0 and req1 both high -> requester 0 wins.
